// File: rtl/pulse_counter.sv
// pulse_counter: gated pulse counter producing counts per minute; define CPM_BCD_EN for BCD output
module pulse_counter #(
    parameter int GATE_CYCLES = 200000000,
    parameter int CPM_MULT = 60
) (
    input  logic        clk_200MHz,
    input  logic        reset,
    input  logic        pulse_in,
    input  logic        access,
    output logic [21:0] result_for_cpm,
    output logic        end_measurement
);
    localparam int GW = $clog2(GATE_CYCLES + 1);
    localparam int PW = 22 + $clog2(CPM_MULT + 1);
`ifdef CPM_BCD_EN
    localparam logic [21:0] LIM = 22'd399999;
`else
    localparam logic [21:0] LIM = 22'h3FFFFF;
`endif
    typedef enum logic [2:0] {IDLE, COUNT, SCALE, CONVERT, DONE, RELEASE} state_t;
    state_t state;
    logic [2:0] sync;
    logic [GW-1:0] gate;
    logic [21:0] count;
    logic [PW-1:0] prod;
    logic [21:0] sat;
    logic hit;
    assign hit = sync[1] & ~sync[2];
    assign prod = PW'(count) * PW'(CPM_MULT);
    assign sat = (prod > PW'(LIM)) ? LIM : prod[21:0];
`ifdef CPM_BCD_EN
    logic [21:0] bin;
    logic [20:0] bcd;
    logic [19:0] adj;
    logic [21:0] nbcd;
    logic [4:0] step;
    // double-dabble adjust: add 3 to every digit >= 5 before the next shift
    always_comb begin
        adj = bcd[19:0];
        for (int i = 0; i < 5; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] + ((bcd[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
    end
    assign nbcd = {bcd[20], adj, bin[21]};
`endif
    // two-flop synchronizer followed by the edge-detect history flop
    always_ff @(posedge clk_200MHz or posedge reset) begin
        if (reset) sync <= '0;
        else sync <= {sync[1:0], pulse_in};
    end
    // measurement sequencer: gate, scale, optional BCD conversion, handshake
    always_ff @(posedge clk_200MHz or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            gate <= '0;
            count <= '0;
            result_for_cpm <= '0;
            end_measurement <= 1'b0;
`ifdef CPM_BCD_EN
            bin <= '0;
            bcd <= '0;
            step <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (access) begin
                    gate <= '0;
                    count <= '0;
                    state <= COUNT;
                end
                COUNT: begin
                    if (hit && count != 22'h3FFFFF) count <= count + 1'b1;
                    gate <= gate + 1'b1;
                    if (gate == GW'(GATE_CYCLES - 1)) state <= SCALE;
                end
                SCALE: begin
`ifdef CPM_BCD_EN
                    bin <= sat;
                    bcd <= '0;
                    step <= '0;
                    state <= CONVERT;
`else
                    result_for_cpm <= sat;
                    end_measurement <= 1'b1;
                    state <= DONE;
`endif
                end
`ifdef CPM_BCD_EN
                CONVERT: begin
                    bin <= {bin[20:0], 1'b0};
                    bcd <= nbcd[20:0];
                    step <= step + 1'b1;
                    if (step == 5'd21) begin
                        result_for_cpm <= nbcd;
                        end_measurement <= 1'b1;
                        state <= DONE;
                    end
                end
`endif
                DONE: if (!access) state <= RELEASE;
                RELEASE: if (access) begin
                    end_measurement <= 1'b0;
                    gate <= '0;
                    count <= '0;
                    state <= COUNT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pulse_counter.sv
// tb_pulse_counter: directed vectors for pulse_counter at CPM_MULT 60 and 10000, GATE_CYCLES 1000
module tb_pulse_counter;
    localparam bit BCD =
`ifdef CPM_BCD_EN
        1'b1;
`else
        1'b0;
`endif
    localparam int LAT = BCD ? 1023 : 1001;
    typedef struct {
        int kind;
        logic [21:0] e60;
        logic [21:0] e10k;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pulse_in = 1'b0;
    logic access = 1'b0;
    logic [21:0] res60, res10k;
    logic end60, end10k;
    logic [21:0] prev60 = '0, prev10k = '0;
    int errors = 0, checks = 0;
    vec_t vecs[6];

    pulse_counter #(.GATE_CYCLES(1000), .CPM_MULT(60)) dut60 (
        .clk_200MHz(clk), .reset(reset), .pulse_in(pulse_in), .access(access),
        .result_for_cpm(res60), .end_measurement(end60));
    pulse_counter #(.GATE_CYCLES(1000), .CPM_MULT(10000)) dut10k (
        .clk_200MHz(clk), .reset(reset), .pulse_in(pulse_in), .access(access),
        .result_for_cpm(res10k), .end_measurement(end10k));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [21:0] act, input logic [21:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // pulse_in level intended to be seen by the edge detector on gate cycle t
    function automatic logic pat(input int kind, input int t);
        case (kind)
            0: return t inside {100, 101, 300, 301, 500, 501, 700, 701, 900, 901};
            1: return t >= 0 && t < 1000 && (t % 4) < 2;
            2: return t == -1 || t == 999;
            3: return t == 0 || t == 1000;
            5: return t >= 0 && t < 1000 && (t % 2) == 0;
            6: return t inside {100, 300, 500};
            default: return 1'b0;
        endcase
    endfunction

    task automatic measure(input string nm, input int kind, input logic [21:0] e60, input logic [21:0] e10k);
        for (int k = -3; k <= LAT; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk($sformatf("%s end_clear60", nm), 22'(end60), 22'd0);
                chk($sformatf("%s end_clear10k", nm), 22'(end10k), 22'd0);
            end
            if (k == 500) begin
                chk($sformatf("%s hold60", nm), res60, prev60);
                chk($sformatf("%s hold10k", nm), res10k, prev10k);
            end
            if (k == LAT - 1) begin
                chk($sformatf("%s early60", nm), 22'(end60), 22'd0);
                chk($sformatf("%s early10k", nm), 22'(end10k), 22'd0);
            end
            if (k == LAT) begin
                chk($sformatf("%s end60", nm), 22'(end60), 22'd1);
                chk($sformatf("%s end10k", nm), 22'(end10k), 22'd1);
                chk($sformatf("%s res60", nm), res60, e60);
                chk($sformatf("%s res10k", nm), res10k, e10k);
            end
            pulse_in = pat(kind, k + 2);
            if (k == -1) access = 1'b1;
        end
        prev60 = e60;
        prev10k = e10k;
    endtask

    task automatic release_dut(input string nm);
        access = 1'b0;
        pulse_in = 1'b0;
        repeat (5) @(negedge clk);
        chk($sformatf("%s release_end60", nm), 22'(end60), 22'd1);
        chk($sformatf("%s release_res10k", nm), res10k, prev10k);
    endtask

    initial begin
        int bad;
        vecs[0] = '{0, BCD ? 22'h000300 : 22'h00012C, BCD ? 22'h050000 : 22'h00C350};
        vecs[1] = '{1, BCD ? 22'h015000 : 22'h003A98, BCD ? 22'h399999 : 22'h2625A0};
        vecs[2] = '{2, BCD ? 22'h000060 : 22'h00003C, BCD ? 22'h010000 : 22'h002710};
        vecs[3] = '{3, BCD ? 22'h000060 : 22'h00003C, BCD ? 22'h010000 : 22'h002710};
        vecs[4] = '{5, BCD ? 22'h030000 : 22'h007530, BCD ? 22'h399999 : 22'h3FFFFF};
        vecs[5] = '{4, 22'h000000, 22'h000000};
        repeat (3) @(negedge clk);
        chk("reset res60", res60, 22'd0);
        chk("reset end60", 22'(end60), 22'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle end10k", 22'(end10k), 22'd0);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) release_dut($sformatf("v%0d", i));
            measure($sformatf("v%0d", i), vecs[i].kind, vecs[i].e60, vecs[i].e10k);
        end
        bad = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (end60 !== 1'b1 || end10k !== 1'b1) bad++;
            pulse_in = (c % 4) < 2;
        end
        chk("done_hold_low_cycles", 22'(bad), 22'd0);
        access = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            pulse_in = (c % 2) == 0;
        end
        chk("release_after_hold end60", 22'(end60), 22'd1);
        measure("dead_time", 4, 22'd0, 22'd0);
        release_dut("abort");
        bad = 0;
        for (int k = -3; k <= 1100; k++) begin
            @(negedge clk);
            if (k == 500) begin
                reset = 1'b1;
                access = 1'b0;
                #1;
                chk("abort res60", res60, 22'd0);
                chk("abort end60", 22'(end60), 22'd0);
                chk("abort res10k", res10k, 22'd0);
                chk("abort end10k", 22'(end10k), 22'd0);
            end
            if (k == 501) reset = 1'b0;
            if (k > 501 && (end60 !== 1'b0 || end10k !== 1'b0)) bad++;
            pulse_in = pat(1, k + 2);
            if (k == -1) access = 1'b1;
        end
        chk("abort no_end_cycles", 22'(bad), 22'd0);
        prev60 = '0;
        prev10k = '0;
        measure("after_abort", 6, BCD ? 22'h000180 : 22'h0000B4, BCD ? 22'h030000 : 22'h007530);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pulse_counter.md
PULSE_COUNTER -- requirements
Module: pulse_counter

Interface
REQ-001 clk_200MHz  input  1  system clock, rising-edge active.
REQ-002 reset  input  1  asynchronous, active-high; clears all state.
REQ-003 pulse_in  input  1  asynchronous detector pulse; one count per rising edge.
REQ-004 access  input  1  downstream ready: 1 = idle/ready, 0 = busy with the current result.
REQ-005 result_for_cpm  output  22  registered measurement result, binary or BCD (see Configuration).
REQ-006 end_measurement  output  1  registered; high = result_for_cpm valid and stable.
REQ-007 Parameter GATE_CYCLES, default 200000000, meaning: gate window length in clocks (1 s).
REQ-008 Parameter CPM_MULT, default 60, meaning: scale factor from counts per gate to counts per minute.

Function
REQ-009 pulse_in SHALL pass a 2-flop synchronizer, then a rising-edge detector (3rd flop); each detected edge is one count.
REQ-010 FSM states SHALL be IDLE, COUNT, SCALE, CONVERT, DONE, RELEASE.
REQ-011 IDLE: on access==1, clear edge count and gate counter, go to COUNT; otherwise stay.
REQ-012 COUNT: exactly GATE_CYCLES clocks; an edge detected on any COUNT cycle, first and last included, SHALL be counted; the edge count is 22-bit and saturates at 22'h3FFFFF.
REQ-013 SCALE (1 clock): product = count x CPM_MULT, computed at >= 22+clog2(CPM_MULT+1) bits, saturated to 22'h3FFFFF, then registered.
REQ-014 CONVERT is entered only when CPM_BCD_EN is defined, otherwise SCALE goes directly to DONE.
REQ-015 end_measurement SHALL rise on the 2nd clock after the last COUNT cycle (binary) or the 24th (BCD).
REQ-016 result_for_cpm SHALL update only on entry to DONE and stay stable until the next DONE entry.
REQ-017 DONE: end_measurement=1; on access==0, go to RELEASE.
REQ-018 RELEASE: end_measurement stays 1; on access==1, end_measurement=0 next clock, go to COUNT directly (counters cleared).
REQ-019 If access stays 1 in DONE, end_measurement SHALL stay high indefinitely; no new measurement starts.
REQ-020 Edges outside COUNT (SCALE, CONVERT, DONE, RELEASE, IDLE) SHALL be discarded; this is dead time.
REQ-021 An edge detector output on the same clock as the COUNT->SCALE transition belongs to the closing window only.

Reset
REQ-022 While reset=1: result_for_cpm=0, end_measurement=0, state=IDLE, all counters and synchronizer flops 0, asynchronously.
REQ-023 Reset during any state SHALL abort the measurement, with no partial result output; after release, operation begins in IDLE.

Configuration
REQ-024 Macro CPM_BCD_EN defined: saturated product is clamped to 399999, then converted by sequential shift-add-3 in CONVERT over exactly 22 clocks.
REQ-025 BCD output format: result_for_cpm[21:20] = hundred-thousands digit (0-3), [19:0] = five BCD digits, MSD first.
REQ-026 Macro CPM_BCD_EN undefined: result_for_cpm = saturated binary product; CONVERT logic SHALL not be synthesized.

Verification
All scenarios use GATE_CYCLES=1000, CPM_MULT=60 unless noted.
REQ-027 5 clean pulses inside gate -> result_for_cpm=22'h00012C (binary) / 22'h000300 (BCD); end_measurement rises at the latency in REQ-015.
REQ-028 Square-wave pulse_in, 2 clocks high / 2 clocks low, for the whole gate -> 250 edges -> 15000 (22'h003A98 binary, 22'h015000 BCD).
REQ-029 CPM_MULT=10000, edge every 2 clocks -> product 5000000 -> 22'h3FFFFF (binary) / 22'h399999 (BCD).
REQ-030 Handshake check:
  - access held 1 after DONE -> end_measurement stays 1 for 5000 clocks.
  - then access=0 for 5 clocks, then 1 -> end_measurement=0 one clock later, COUNT restarts.
  - pulses injected during DONE are not counted in the next result.
REQ-031 reset pulsed for 1 clock at COUNT cycle 500 -> outputs 0 immediately, no end_measurement; next full gate with 3 pulses -> 180.
REQ-032 Pulse edge on the last COUNT cycle is counted; edge on the first SCALE cycle is not: 1 pulse at each -> 60.
